// File: rtl/trace_deserializer.sv
// -----------------------------------------------------------------------------
// trace_deserializer
//
// Collects beats from 2^EXP_TRACES_I parallel trace lanes, LSB first, into
// TRB_WIDTH-bit words. A finished word is held in DATA_O and flagged pending
// until the downstream side takes it with STORE_PERM_I. The input stalls only
// when the next beat would finish a word while an unstored word is pending.
//
// Ports:
//   CLK_I          sole clock, rising edge
//   RST_I          asynchronous active-high reset
//   EXP_TRACES_I   log2 of active lane count (clamped to log2(TRB_MAX_TRACES))
//   STORE_PERM_I   downstream may accept a word this cycle
//   TRACE_VALID_I  TRACE_I holds a valid beat
//   TRACE_I        trace lanes, only the low 2^EXP_TRACES_I are used
//   DATA_O         last completed word
//   STORE_O        DATA_O is stored this cycle (pending AND STORE_PERM_I)
//   TRACE_READY_O  a beat can be accepted this cycle
//
// Optional build macro: TRACE_DESERIALIZER_ASSERT_EN adds concurrent
// assertions on the store/overwrite protocol.
// -----------------------------------------------------------------------------
module trace_deserializer #(
    parameter int unsigned TRB_WIDTH       = 32,
    parameter int unsigned TRB_MAX_TRACES  = 8,
    parameter int unsigned TRB_NTRACE_BITS = 2
) (
    input  logic                       CLK_I,
    input  logic                       RST_I,
    input  logic [TRB_NTRACE_BITS-1:0] EXP_TRACES_I,
    input  logic                       STORE_PERM_I,
    input  logic                       TRACE_VALID_I,
    input  logic [TRB_MAX_TRACES-1:0]  TRACE_I,
    output logic [TRB_WIDTH-1:0]       DATA_O,
    output logic                       STORE_O,
    output logic                       TRACE_READY_O
);

    localparam int unsigned LOG2_MAX = $clog2(TRB_MAX_TRACES);
    // Wide enough to hold TRB_WIDTH itself (beat count at n = 1).
    localparam int unsigned CNT_W    = $clog2(TRB_WIDTH) + 1;

    // State
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [TRB_WIDTH-1:0]       partial_q, partial_d;
    logic [TRB_WIDTH-1:0]       data_q, data_d;
    logic                       pending_q, pending_d;
    logic [TRB_NTRACE_BITS-1:0] exp_q, exp_d;

    // Next-state helpers
    logic [CNT_W-1:0]          exp_eff;
    logic [CNT_W:0]            n_lanes;
    logic [TRB_MAX_TRACES-1:0] lane_ones;
    logic [TRB_MAX_TRACES-1:0] lane_mask;
    logic [CNT_W-1:0]          last_beat;
    logic                      exp_changed;
    logic [CNT_W-1:0]          cnt_eff;
    logic [TRB_WIDTH-1:0]      partial_eff;
    logic [CNT_W-1:0]          shift;
    logic [TRB_WIDTH-1:0]      beat_word;
    logic [TRB_WIDTH-1:0]      assembled;
    logic                      would_complete;
    logic                      accept;
    logic                      complete;
    logic                      ready;
    logic                      store;

    always_comb begin
        // Clamp the lane exponent to what the lane bus can carry.
        if (32'(EXP_TRACES_I) > LOG2_MAX) begin
            exp_eff = CNT_W'(LOG2_MAX);
        end else begin
            exp_eff = CNT_W'(EXP_TRACES_I);
        end
        n_lanes   = (CNT_W + 1)'(1) << exp_eff;
        lane_ones = '1;
        // A shift by the full bus width yields zero, so the mask becomes all ones.
        lane_mask = ~(lane_ones << n_lanes);
        last_beat = CNT_W'(TRB_WIDTH >> exp_eff) - CNT_W'(1);

        // A lane-count change discards the partial word; a beat on that same
        // edge becomes beat 0 of the new word.
        exp_changed = (EXP_TRACES_I != exp_q);
        cnt_eff     = exp_changed ? '0 : cnt_q;
        partial_eff = exp_changed ? '0 : partial_q;

        shift     = cnt_eff << exp_eff;
        beat_word = TRB_WIDTH'(TRACE_I & lane_mask) << shift;
        assembled = partial_eff | beat_word;

        would_complete = (cnt_eff == last_beat);
        store          = pending_q & STORE_PERM_I;
        // Stall only when finishing a word would clobber an unstored one.
        ready          = ~RST_I & ~(pending_q & ~STORE_PERM_I & would_complete);
        accept         = TRACE_VALID_I & ready;
        complete       = accept & would_complete;

        cnt_d     = cnt_eff;
        partial_d = partial_eff;
        data_d    = data_q;
        pending_d = pending_q;
        exp_d     = EXP_TRACES_I;

        if (accept) begin
            if (would_complete) begin
                cnt_d     = '0;
                partial_d = '0;
                data_d    = assembled;
            end else begin
                cnt_d     = cnt_eff + CNT_W'(1);
                partial_d = assembled;
            end
        end

        // A completion on the store edge keeps the flag set for the new word.
        if (complete) begin
            pending_d = 1'b1;
        end else if (store) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            cnt_q     <= '0;
            partial_q <= '0;
            data_q    <= '0;
            pending_q <= 1'b0;
            exp_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
            data_q    <= data_d;
            pending_q <= pending_d;
            exp_q     <= exp_d;
        end
    end

    assign DATA_O        = data_q;
    assign STORE_O       = store;
    assign TRACE_READY_O = ready;

`ifdef TRACE_DESERIALIZER_ASSERT_EN
    store_needs_perm_a : assert property (
        @(posedge CLK_I) disable iff (RST_I) STORE_O |-> STORE_PERM_I
    ) else $error("trace_deserializer: STORE_O asserted without STORE_PERM_I");

    no_overwrite_a : assert property (
        @(posedge CLK_I) disable iff (RST_I) complete |-> !(pending_q && !STORE_PERM_I)
    ) else $error("trace_deserializer: completed word overwrote an unstored pending word");
`endif

endmodule

// File: tb/tb_trace_deserializer.sv
module tb_trace_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  exp_tr;
    logic        perm;
    logic        valid;
    logic [7:0]  trace;
    logic [31:0] data;
    logic        store;
    logic        ready;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: accepted bits in arrival order, pending flag, and
    // the scoreboard of words awaiting a store.
    bit          mbits[$];
    logic        mpend;
    logic [1:0]  mprev;
    logic [31:0] sb[$];

    trace_deserializer #(
        .TRB_WIDTH      (32),
        .TRB_MAX_TRACES (8),
        .TRB_NTRACE_BITS(2)
    ) dut (
        .CLK_I        (clk),
        .RST_I        (rst),
        .EXP_TRACES_I (exp_tr),
        .STORE_PERM_I (perm),
        .TRACE_VALID_I(valid),
        .TRACE_I      (trace),
        .DATA_O       (data),
        .STORE_O      (store),
        .TRACE_READY_O(ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    endtask

    // Monitor: every store must have permission and match the oldest word.
    initial begin
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (!rst && store) begin
                chk("store_perm", 32'(perm), 32'd1);
                chk("store_has_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    w = sb.pop_front();
                    chk("store_data", data, w);
                end
            end
        end
    end

    // One clock: drive at posedge+1, check ready at negedge, update model at posedge.
    task automatic step(input logic v, input logic [7:0] t, input logic p, output logic acc);
        logic        exp_rdy;
        logic        done;
        logic        st;
        logic [31:0] w;
        int          n;
        int          cur;
        valid = v;
        trace = t;
        perm  = p;
        n   = 1 << exp_tr;
        cur = (exp_tr != mprev) ? 0 : mbits.size();
        exp_rdy = !(mpend && !p && (cur + n == 32));
        @(negedge clk);
        chk("trace_ready", 32'(ready), 32'(exp_rdy));
        @(posedge clk);
        acc = v && exp_rdy;
        if (exp_tr != mprev) mbits.delete();
        mprev = exp_tr;
        st   = mpend && p;
        done = 1'b0;
        if (acc) begin
            for (int i = 0; i < n; i++) mbits.push_back(t[i]);
            if (mbits.size() == 32) begin
                for (int i = 0; i < 32; i++) w[i] = mbits[i];
                sb.push_back(w);
                mbits.delete();
                done = 1'b1;
            end
        end
        if (done) mpend = 1'b1;
        else if (st) mpend = 1'b0;
        #1;
    endtask

    task automatic idle(input int cycles, input logic p);
        logic acc;
        for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, p, acc);
    endtask

    task automatic send_beat(input logic [7:0] t, input logic p);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            step(1'b1, t, p, acc);
            tries++;
        end
        chk("beat_accept_timeout", 32'(acc), 32'd1);
    endtask

    // Sends `beats` beats of `word` with n = 2^e lanes and `gap` idle cycles after each.
    task automatic send_word(input logic [31:0] word, input int beats, input int gap,
                             input logic p);
        int          n;
        logic [31:0] sh;
        logic [7:0]  lanes;
        n = 1 << exp_tr;
        for (int k = 0; k < beats; k++) begin
            sh    = word >> (k * n);
            lanes = sh[7:0] & 8'((1 << n) - 1);
            // Upper unused lanes carry noise that must be ignored.
            lanes = lanes | (8'($urandom) & ~8'((1 << n) - 1));
            send_beat(lanes, p);
            if (gap > 0) idle(gap, p);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        #1;
        chk("reset_data", data, 32'h0);
        chk("reset_store", 32'(store), 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_data_hold", data, 32'h0);
        chk("reset_ready_hold", 32'(ready), 32'd0);
        mbits.delete();
        sb.delete();
        mpend = 1'b0;
        mprev = exp_tr;
        rst   = 1'b0;
    endtask

    task automatic set_exp(input logic [1:0] e);
        exp_tr = e;
        idle(2, 1'b1);
    endtask

    initial begin
        logic acc;
        rst    = 1'b1;
        exp_tr = 2'd0;
        perm   = 1'b0;
        valid  = 1'b0;
        trace  = 8'h00;
        mpend  = 1'b0;
        mprev  = 2'd0;
        @(posedge clk);
        #1;
        do_reset();
        idle(2, 1'b1);

        // 1 lane, 32 beats.
        set_exp(2'd0);
        send_word(32'hA5A51234, 32, 0, 1'b1);
        idle(3, 1'b1);
        chk("exp0_word", data, 32'hA5A51234);

        // 8 lanes, bytes 0x34,0x12,0xA5,0xA5.
        set_exp(2'd3);
        send_word(32'hA5A51234, 4, 0, 1'b1);
        idle(3, 1'b1);
        chk("exp3_word", data, 32'hA5A51234);

        set_exp(2'd1);
        send_word(32'hA5A51234, 16, 0, 1'b1);
        idle(3, 1'b1);
        chk("exp1_word", data, 32'hA5A51234);

        set_exp(2'd2);
        send_word(32'hA5A51234, 8, 0, 1'b1);
        idle(3, 1'b1);
        chk("exp2_word", data, 32'hA5A51234);

        // Back-pressure: second word's last beat stalls until permission.
        set_exp(2'd3);
        perm = 1'b0;
        idle(1, 1'b0);
        send_word(32'h44332211, 4, 0, 1'b0);
        send_word(32'h00776655, 3, 0, 1'b0);
        step(1'b1, 8'h88, 1'b0, acc);
        chk("stall_store_low", 32'(store), 32'd0);
        step(1'b1, 8'h88, 1'b0, acc);
        chk("stall_ready_low", 32'(ready), 32'd0);
        chk("stall_data_word1", data, 32'h44332211);
        step(1'b1, 8'h88, 1'b1, acc);
        idle(3, 1'b1);
        chk("stall_data_word2", data, 32'h88776655);

        // Gapped valid, 4 lanes.
        set_exp(2'd2);
        send_word(32'hA5A51234, 8, 2, 1'b1);
        idle(3, 1'b1);
        chk("gapped_word", data, 32'hA5A51234);

        // Reset mid-word discards the partial word.
        set_exp(2'd0);
        send_word(32'hFFFFFFFF, 10, 0, 1'b1);
        do_reset();
        idle(2, 1'b1);
        send_word(32'h5A5A0F0F, 32, 0, 1'b1);
        idle(3, 1'b1);
        chk("post_reset_word", data, 32'h5A5A0F0F);

        // Randomized traffic with occasional lane-count changes while idle.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 24) == 0) begin
                exp_tr = 2'($urandom_range(0, 3));
                step(1'b0, 8'($urandom), 1'($urandom_range(0, 1)), acc);
            end else begin
                step(1'($urandom_range(0, 3) != 0), 8'($urandom),
                     1'($urandom_range(0, 2) != 0), acc);
            end
        end
        idle(6, 1'b1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("model_pending_clear", 32'(mpend), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
